// File: rtl/l2_stream_buffer.sv
// l2_stream_buffer: single-entry next-line prefetch buffer sitting between the
// L2 "next" port and physical memory. Holds one prefetched line, answers demand
// lookups with hit/miss, fetches lines over a read-only memory port and drops
// stale data when a write-back of the same line is snooped.
module l2_stream_buffer #(
   parameter int ADDR_W   = 32,
   parameter int LINE_W   = 256,
   parameter int OFFSET_W = 5,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] sb_addr,
   input  logic              mem_action_n_cyc,
   input  logic              mem_action_n_stb,
   output logic              mem_n_resp,
   output logic              mem_n_retry,
   output logic [LINE_W-1:0] sb_rdata,
   input  logic              snoop_valid,
   input  logic [ADDR_W-1:0] snoop_addr,
   output logic              pmem_cyc,
   output logic              pmem_stb,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   input  logic              pmem_retry,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  prefetch_count
);

   localparam int TAG_W = ADDR_W - OFFSET_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;

   state_t              state_r;
   logic                entry_valid_r;
   logic [TAG_W-1:0]    entry_tag_r;
   logic [LINE_W-1:0]   entry_data_r;
   logic [TAG_W-1:0]    pend_tag_r;
   logic                pend_kill_r;
   logic                resp_hit_r;
   logic                mem_n_resp_r;
   logic                mem_n_retry_r;
   logic                pmem_req_r;
   logic [ADDR_W-1:0]   pmem_address_r;
   logic [CNT_W-1:0]    hit_count_r;
   logic [CNT_W-1:0]    prefetch_count_r;

   logic [TAG_W-1:0]    req_tag_s;
   logic [TAG_W-1:0]    snoop_tag_s;
   logic                entry_match_s;
   logic                snoop_entry_s;
   logic                snoop_pend_s;
   logic                accept_s;
   logic                unused_offset_s;

   // Saturating increment for the statistics counters; holds at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   assign req_tag_s       = sb_addr[ADDR_W-1:OFFSET_W];
   assign snoop_tag_s     = snoop_addr[ADDR_W-1:OFFSET_W];
   assign unused_offset_s = ^{sb_addr[OFFSET_W-1:0], snoop_addr[OFFSET_W-1:0]};

   // Tag compares and fill acceptance, decoded from registered state and inputs.
   always_comb begin
      entry_match_s = entry_valid_r && (entry_tag_r == req_tag_s);
      snoop_entry_s = snoop_valid && (snoop_tag_s == entry_tag_r);
      snoop_pend_s  = snoop_valid && (snoop_tag_s == pend_tag_r);
      accept_s      = pmem_resp && !pmem_retry;
   end

   // Buffer control FSM, entry state, registered outputs and statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r          <= ST_IDLE;
         entry_valid_r    <= 1'b0;
         entry_tag_r      <= {TAG_W{1'b0}};
         entry_data_r     <= {LINE_W{1'b0}};
         pend_tag_r       <= {TAG_W{1'b0}};
         pend_kill_r      <= 1'b0;
         resp_hit_r       <= 1'b0;
         mem_n_resp_r     <= 1'b0;
         mem_n_retry_r    <= 1'b0;
         pmem_req_r       <= 1'b0;
         pmem_address_r   <= {ADDR_W{1'b0}};
         hit_count_r      <= {CNT_W{1'b0}};
         prefetch_count_r <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               mem_n_resp_r  <= 1'b0;
               mem_n_retry_r <= 1'b0;
               if (mem_action_n_cyc && mem_action_n_stb) begin
                  // Demand lookup: a hit migrates the line into the L2.
                  resp_hit_r    <= entry_match_s;
                  mem_n_resp_r  <= 1'b1;
                  mem_n_retry_r <= entry_match_s;
                  state_r       <= ST_RESPOND;
                  if (entry_match_s) begin
                     entry_valid_r <= 1'b0;
                  end
               end else if (mem_action_n_cyc && entry_match_s) begin
                  // Prefetch of a line already resident: acknowledge only.
                  resp_hit_r    <= 1'b0;
                  mem_n_resp_r  <= 1'b1;
                  mem_n_retry_r <= 1'b0;
                  state_r       <= ST_RESPOND;
               end else if (mem_action_n_cyc) begin
                  pend_tag_r     <= req_tag_s;
                  pend_kill_r    <= 1'b0;
                  entry_valid_r  <= 1'b0;
                  resp_hit_r     <= 1'b0;
                  pmem_req_r     <= 1'b1;
                  pmem_address_r <= {req_tag_s, {OFFSET_W{1'b0}}};
                  state_r        <= ST_FETCH;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_FETCH: begin
               if (accept_s) begin
                  entry_data_r     <= pmem_rdata;
                  entry_tag_r      <= pend_tag_r;
                  entry_valid_r    <= !pend_kill_r && !snoop_pend_s;
                  prefetch_count_r <= sat_inc(prefetch_count_r);
                  pmem_req_r       <= 1'b0;
                  pmem_address_r   <= {ADDR_W{1'b0}};
                  mem_n_resp_r     <= 1'b1;
                  mem_n_retry_r    <= 1'b0;
                  state_r          <= ST_RESPOND;
               end else if (snoop_pend_s) begin
                  pend_kill_r <= 1'b1;
               end else begin
                  state_r <= ST_FETCH;
               end
            end
            ST_RESPOND: begin
               mem_n_resp_r  <= 1'b0;
               mem_n_retry_r <= 1'b0;
               if (resp_hit_r) begin
                  hit_count_r <= sat_inc(hit_count_r);
               end
               state_r <= ST_IDLE;
            end
            default: begin
               mem_n_resp_r  <= 1'b0;
               mem_n_retry_r <= 1'b0;
               pmem_req_r    <= 1'b0;
               state_r       <= ST_IDLE;
            end
         endcase
         // A write-back of the resident line always invalidates it; during
         // FETCH the entry is already invalid and the fill path owns it.
         if (snoop_entry_s && (state_r != ST_FETCH)) begin
            entry_valid_r <= 1'b0;
         end
      end
   end

   assign mem_n_resp     = mem_n_resp_r;
   assign mem_n_retry    = mem_n_retry_r;
   assign sb_rdata       = entry_data_r;
   assign pmem_cyc       = pmem_req_r;
   assign pmem_stb       = pmem_req_r;
   assign pmem_write     = 1'b0;
   assign pmem_address   = pmem_address_r;
   assign hit_count      = hit_count_r;
   assign prefetch_count = prefetch_count_r;

endmodule

// File: tb/tb_l2_stream_buffer.sv
// Scoreboard bench for l2_stream_buffer: directed requests push expected
// responses; a monitor pops and compares whenever mem_n_resp is seen.
module tb_l2_stream_buffer;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  sb_addr;
   logic         cyc, stb;
   logic         mem_n_resp, mem_n_retry;
   logic [255:0] sb_rdata;
   logic         snoop_valid;
   logic [31:0]  snoop_addr;
   logic         pmem_cyc, pmem_stb, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_rdata;
   logic         pmem_resp, pmem_retry;
   logic [15:0]  hit_count, prefetch_count;

   // second instance with narrow counters to exercise saturation
   logic         s_resp, s_retry, s_pcyc, s_pstb, s_pwr;
   logic [255:0] s_rdata;
   logic [31:0]  s_paddr;
   logic [1:0]   s_hits, s_pfs;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc_cnt = 0;
   int fills = 0;
   int mem_lat = 1;
   int mem_retry_n = 0;
   logic [31:0] exp_fetch_addr = 32'h0;

   typedef struct {
      logic         hit;
      logic         chk;
      logic [255:0] data;
      int           at;
   } exp_t;
   exp_t exp_q[$];

   l2_stream_buffer dut (
      .clk(clk), .rst(rst), .sb_addr(sb_addr),
      .mem_action_n_cyc(cyc), .mem_action_n_stb(stb),
      .mem_n_resp(mem_n_resp), .mem_n_retry(mem_n_retry), .sb_rdata(sb_rdata),
      .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
      .pmem_cyc(pmem_cyc), .pmem_stb(pmem_stb), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_rdata(pmem_rdata),
      .pmem_resp(pmem_resp), .pmem_retry(pmem_retry),
      .hit_count(hit_count), .prefetch_count(prefetch_count)
   );

   l2_stream_buffer #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .sb_addr(sb_addr),
      .mem_action_n_cyc(cyc), .mem_action_n_stb(stb),
      .mem_n_resp(s_resp), .mem_n_retry(s_retry), .sb_rdata(s_rdata),
      .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
      .pmem_cyc(s_pcyc), .pmem_stb(s_pstb), .pmem_write(s_pwr),
      .pmem_address(s_paddr), .pmem_rdata(pmem_rdata),
      .pmem_resp(pmem_resp), .pmem_retry(pmem_retry),
      .hit_count(s_hits), .prefetch_count(s_pfs)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic logic [255:0] mem_line(input logic [31:0] a);
      logic [255:0] l;
      if (a[31:5] == 27'h83) l = {32{8'hA5}};
      else l = {8{a ^ 32'h5A5A_C3C3}};
      return l;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory model: counts cycles of an outstanding request, raises retry for
   // the first mem_retry_n cycles and resp from cycle mem_lat onward.
   initial begin
      int age;
      age = 0;
      pmem_resp = 1'b0; pmem_retry = 1'b0; pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (pmem_cyc) age++; else age = 0;
         pmem_retry = pmem_cyc && (age <= mem_retry_n);
         pmem_resp  = pmem_cyc && (age >= mem_lat);
         pmem_rdata = pmem_resp ? mem_line(pmem_address) : '0;
         if (pmem_resp && !pmem_retry) fills++;
      end
   end

   // Monitor: response scoreboard and fetch-address stability.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pmem_cyc) check("pmem_address", pmem_address, exp_fetch_addr);
         if (mem_n_resp) begin
            if (exp_q.size() == 0) begin
               check("unexpected_resp", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("resp_cycle", e.at, cyc_cnt);
               check("resp_hit", mem_n_retry, e.hit);
               if (e.chk) check("resp_data", sb_rdata, e.data);
            end
         end
      end
   end

   // Issue one request; snoop_at = 0 snoops with the request, k > 0 snoops
   // k cycles later, negative means no snoop. exp_delay counts cycles from
   // the sampling edge to the response.
   task automatic issue(input logic [31:0] a, input logic is_demand, input int snoop_at,
                        input logic [31:0] sa, input logic exp_hit, input logic chk,
                        input logic [255:0] data, input int exp_delay);
      exp_t e;
      @(negedge clk);
      sb_addr = a; stb = is_demand; cyc = 1'b1;
      snoop_valid = (snoop_at == 0); snoop_addr = sa;
      if (!is_demand) exp_fetch_addr = {a[31:5], 5'b0};
      e.hit = exp_hit; e.chk = chk; e.data = data; e.at = cyc_cnt + exp_delay;
      exp_q.push_back(e);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         cyc = 1'b0;
         snoop_valid = (k == snoop_at);
         if (exp_q.size() == 0) break;
      end
      snoop_valid = 1'b0;
      if (exp_q.size() != 0) begin
         check("resp_timeout", 1'b1, 1'b0);
         exp_q.delete();
      end
   endtask

   initial begin
      int f0;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; sb_addr = '0;
      snoop_valid = 1'b0; snoop_addr = '0;
      repeat (3) @(negedge clk);
      check("rst_resp", {mem_n_resp, mem_n_retry, pmem_cyc, pmem_stb, pmem_write}, 5'b0);
      check("rst_addr", pmem_address, 32'h0);
      check("rst_rdata", sb_rdata, 256'h0);
      check("rst_counts", {hit_count, prefetch_count}, 32'h0);
      rst = 1'b0;

      // demand miss on empty buffer
      issue(32'h0000_1040, 1'b1, -1, 32'h0, 1'b0, 1'b0, '0, 1);
      @(negedge clk);
      check("no_fetch_on_demand", fills, 0);
      check("hit_count_0", hit_count, 16'd0);

      // prefetch with 4-cycle memory latency, then hit and re-miss
      mem_lat = 4;
      issue(32'h0000_1060, 1'b0, -1, 32'h0, 1'b0, 1'b0, '0, 5);
      mem_lat = 1;
      @(negedge clk);
      check("pf_count_1", prefetch_count, 16'd1);
      issue(32'h0000_1074, 1'b1, -1, 32'h0, 1'b1, 1'b1, {32{8'hA5}}, 1);
      @(negedge clk);
      check("hit_count_1", hit_count, 16'd1);
      issue(32'h0000_1060, 1'b1, -1, 32'h0, 1'b0, 1'b0, '0, 1);

      // memory retry held 3 cycles
      f0 = fills;
      mem_retry_n = 3;
      issue(32'h0000_2000, 1'b0, -1, 32'h0, 1'b0, 1'b0, '0, 5);
      mem_retry_n = 0;
      @(negedge clk);
      check("retry_one_fill", fills - f0, 1);
      check("pf_count_2", prefetch_count, 16'd2);
      issue(32'h0000_2000, 1'b1, -1, 32'h0, 1'b1, 1'b1, mem_line(32'h0000_2000), 1);

      // snoop during FETCH kills the pending fill
      mem_lat = 3;
      issue(32'h0000_2000, 1'b0, 1, 32'h0000_2010, 1'b0, 1'b0, '0, 4);
      mem_lat = 1;
      issue(32'h0000_2000, 1'b1, -1, 32'h0, 1'b0, 1'b0, '0, 1);

      // resident prefetch, snoop concurrent with hit
      issue(32'h0000_5000, 1'b0, -1, 32'h0, 1'b0, 1'b0, '0, 2);
      f0 = fills;
      issue(32'h0000_5000, 1'b0, -1, 32'h0, 1'b0, 1'b0, '0, 1);
      check("resident_no_fill", fills - f0, 0);
      issue(32'h0000_5004, 1'b1, 0, 32'h0000_5008, 1'b1, 1'b1, mem_line(32'h0000_5000), 1);
      issue(32'h0000_5000, 1'b1, -1, 32'h0, 1'b0, 1'b0, '0, 1);
      @(negedge clk);
      check("hit_count_3", hit_count, 16'd3);

      // snoop of resident line while idle
      issue(32'h0000_6000, 1'b0, -1, 32'h0, 1'b0, 1'b0, '0, 2);
      issue(32'h0000_7000, 1'b1, 0, 32'h0000_6000, 1'b0, 1'b0, '0, 1);
      issue(32'h0000_6000, 1'b1, -1, 32'h0, 1'b0, 1'b0, '0, 1);

      // snoop on the very fill edge wins
      mem_lat = 2;
      issue(32'h0000_8000, 1'b0, 2, 32'h0000_8000, 1'b0, 1'b0, '0, 3);
      mem_lat = 1;
      issue(32'h0000_8000, 1'b1, -1, 32'h0, 1'b0, 1'b0, '0, 1);
      @(negedge clk);
      check("pf_count_6", prefetch_count, 16'd6);

      // reset in the middle of a fetch
      mem_lat = 20;
      exp_fetch_addr = 32'h0000_3000;
      @(negedge clk);
      sb_addr = 32'h0000_3000; stb = 1'b0; cyc = 1'b1;
      @(negedge clk);
      cyc = 1'b0;
      @(negedge clk);
      check("fetch_active", pmem_cyc, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rst_drop_cyc", {pmem_cyc, pmem_stb, mem_n_resp}, 3'b0);
      check("rst_counts_2", {hit_count, prefetch_count}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      mem_lat = 1;
      issue(32'h0000_3000, 1'b1, -1, 32'h0, 1'b0, 1'b0, '0, 1);

      // repeated hits: main counters count, narrow counters saturate
      for (int i = 0; i < 5; i++) begin
         issue(32'h0000_9000 + 32'(i) * 32'h20, 1'b0, -1, 32'h0, 1'b0, 1'b0, '0, 2);
         issue(32'h0000_9000 + 32'(i) * 32'h20, 1'b1, -1, 32'h0, 1'b1, 1'b1,
               mem_line(32'h0000_9000 + 32'(i) * 32'h20), 1);
      end
      @(negedge clk);
      check("hit_count_5", hit_count, 16'd5);
      check("pf_count_5", prefetch_count, 16'd5);
      check("sat_hits", s_hits, 2'd3);
      check("sat_pfs", s_pfs, 2'd3);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
